// File: rtl/aurora_link_pkg.sv
// Shared state encoding, reset decode and sizing helpers for the Aurora link supervisor.
package aurora_link_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned STATE_W       = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISABLED = 3'd0,
    ST_RST_GT   = 3'd1,
    ST_RST_CORE = 3'd2,
    ST_WAIT_UP  = 3'd3,
    ST_UP       = 3'd4
  } ch_state_e;

  typedef struct packed {
    logic core_reset;
    logic gt_reset;
  } rst_ctrl_t;

  // Unused encodings fall back to the fully-reset pair so the core is never left half-released.
  function automatic rst_ctrl_t decode_rst(input ch_state_e st);
    rst_ctrl_t r;
    case (st)
      ST_WAIT_UP, ST_UP: r = '{core_reset: 1'b0, gt_reset: 1'b0};
      ST_RST_CORE:       r = '{core_reset: 1'b1, gt_reset: 1'b0};
      default:           r = '{core_reset: 1'b1, gt_reset: 1'b1};
    endcase
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aurora_link_supervisor_ch.sv
// Single-channel Aurora reset sequencer and link watchdog with input synchronizers
// and saturating event counters.
module aurora_link_supervisor_ch
  import aurora_link_pkg::*;
#(
  parameter int unsigned GT_RST_CYC    = 128,
  parameter int unsigned CORE_RST_CYC  = 64,
  parameter int unsigned UP_TIMEOUT    = 2**20,
  parameter int unsigned DOWN_DEBOUNCE = 16,
  parameter int unsigned MAX_RETRY     = 4,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch_enable,
  input  logic               force_retrain,
  input  logic               clr_counters,
  input  logic               channel_up,
  input  logic               hard_err,
  output logic               core_reset,
  output logic               core_gt_reset,
  output logic               link_ok,
  output logic [STATE_W-1:0] ch_state,
  output logic [CNT_W-1:0]   down_count,
  output logic [CNT_W-1:0]   retry_count
);

  localparam int unsigned TMR_MAX = max3(GT_RST_CYC, CORE_RST_CYC, UP_TIMEOUT);
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned DBC_W   = (DOWN_DEBOUNCE > 1) ? $clog2(DOWN_DEBOUNCE) : 1;
  localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TMR_W-1:0] GT_LAST   = TMR_W'(GT_RST_CYC - 1);
  localparam logic [TMR_W-1:0] CORE_LAST = TMR_W'(CORE_RST_CYC - 1);
  localparam logic [TMR_W-1:0] UP_LAST   = TMR_W'(UP_TIMEOUT - 1);
  localparam logic [DBC_W-1:0] DBC_LAST  = DBC_W'(DOWN_DEBOUNCE - 1);
  localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);

  ch_state_e          state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DBC_W-1:0]   dbc_q, dbc_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               up_meta_q, up_meta_d, up_sync_q, up_sync_d;
  logic               err_meta_q, err_meta_d, err_sync_q, err_sync_d;
  logic [CNT_W-1:0]   down_q, down_d, rcnt_q, rcnt_d;
  logic               core_reset_q, core_reset_d;
  logic               gt_reset_q, gt_reset_d;
  logic               link_ok_q, link_ok_d;
  logic [STATE_W-1:0] ch_state_q, ch_state_d;
  logic               restart, down_ev, retry_ev;
  rst_ctrl_t          rst_ctrl;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    restart    = 1'b0;
    down_ev    = 1'b0;
    retry_ev   = 1'b0;
    up_meta_d  = channel_up;
    up_sync_d  = up_meta_q;
    err_meta_d = hard_err;
    err_sync_d = err_meta_q;

    case (state_q)
      ST_DISABLED: begin
        if (ch_enable) state_d = ST_RST_GT;
      end
      ST_RST_GT: begin
        retry_d = '0;
        if (timer_q == GT_LAST) state_d = ST_RST_CORE;
      end
      ST_RST_CORE: begin
        if (timer_q == CORE_LAST) state_d = ST_WAIT_UP;
      end
      ST_WAIT_UP: begin
        if (up_sync_q) begin
          state_d = ST_UP;
        end else if (timer_q == UP_LAST) begin
          retry_ev = 1'b1;
          if (retry_q >= RTY_LAST) begin
            state_d = ST_RST_GT;
          end else begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_RST_CORE;
          end
        end
      end
      ST_UP: begin
        if (err_sync_q || (!up_sync_q && dbc_q == DBC_LAST)) begin
          down_ev = 1'b1;
          state_d = ST_RST_CORE;
        end
      end
      default: state_d = ST_DISABLED;
    endcase

    // Overrides in increasing priority: retrain beats link events, disable beats everything.
    if (force_retrain && state_q != ST_DISABLED) begin
      state_d  = ST_RST_GT;
      restart  = 1'b1;
      down_ev  = 1'b0;
      retry_ev = 1'b0;
    end
    if (!ch_enable) begin
      state_d  = ST_DISABLED;
      down_ev  = 1'b0;
      retry_ev = 1'b0;
    end

    if (state_d != state_q || restart || state_d == ST_DISABLED || state_d == ST_UP)
      timer_d = '0;
    else
      timer_d = timer_q + TMR_W'(1);

    dbc_d = '0;
    if (state_q == ST_UP && state_d == ST_UP && !up_sync_q) dbc_d = dbc_q + DBC_W'(1);

    if (clr_counters)       down_d = '0;
    else if (down_ev && !(&down_q)) down_d = down_q + CNT_W'(1);
    else                    down_d = down_q;

    if (clr_counters)       rcnt_d = '0;
    else if (retry_ev && !(&rcnt_q)) rcnt_d = rcnt_q + CNT_W'(1);
    else                    rcnt_d = rcnt_q;

    rst_ctrl     = decode_rst(state_d);
    core_reset_d = rst_ctrl.core_reset;
    gt_reset_d   = rst_ctrl.gt_reset;
    link_ok_d    = (state_d == ST_UP);
    ch_state_d   = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DISABLED;
      timer_q      <= '0;
      dbc_q        <= '0;
      retry_q      <= '0;
      up_meta_q    <= 1'b0;
      up_sync_q    <= 1'b0;
      err_meta_q   <= 1'b0;
      err_sync_q   <= 1'b0;
      down_q       <= '0;
      rcnt_q       <= '0;
      core_reset_q <= 1'b1;
      gt_reset_q   <= 1'b1;
      link_ok_q    <= 1'b0;
      ch_state_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dbc_q        <= dbc_d;
      retry_q      <= retry_d;
      up_meta_q    <= up_meta_d;
      up_sync_q    <= up_sync_d;
      err_meta_q   <= err_meta_d;
      err_sync_q   <= err_sync_d;
      down_q       <= down_d;
      rcnt_q       <= rcnt_d;
      core_reset_q <= core_reset_d;
      gt_reset_q   <= gt_reset_d;
      link_ok_q    <= link_ok_d;
      ch_state_q   <= ch_state_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign core_gt_reset = gt_reset_q;
  assign link_ok       = link_ok_q;
  assign ch_state      = ch_state_q;
  assign down_count    = down_q;
  assign retry_count   = rcnt_q;

endmodule

// File: rtl/aurora_link_supervisor.sv
// Reset sequencer and link watchdog for NUM_CH Aurora 8b10b channels on the shared init clock.
module aurora_link_supervisor
  import aurora_link_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned GT_RST_CYC    = 128,
  parameter int unsigned CORE_RST_CYC  = 64,
  parameter int unsigned UP_TIMEOUT    = 2**20,
  parameter int unsigned DOWN_DEBOUNCE = 16,
  parameter int unsigned MAX_RETRY     = 4,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic                      init_clk_in,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         force_retrain,
  input  logic                      clr_counters,
  input  logic [NUM_CH-1:0]         channel_up,
  input  logic [NUM_CH-1:0]         hard_err,
  output logic [NUM_CH-1:0]         core_reset,
  output logic [NUM_CH-1:0]         core_gt_reset,
  output logic [NUM_CH-1:0]         link_ok,
  output logic [STATE_W*NUM_CH-1:0] ch_state,
  output logic [CNT_W*NUM_CH-1:0]   down_count,
  output logic [CNT_W*NUM_CH-1:0]   retry_count
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aurora_link_supervisor_ch #(
      .GT_RST_CYC    (GT_RST_CYC),
      .CORE_RST_CYC  (CORE_RST_CYC),
      .UP_TIMEOUT    (UP_TIMEOUT),
      .DOWN_DEBOUNCE (DOWN_DEBOUNCE),
      .MAX_RETRY     (MAX_RETRY),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk           (init_clk_in),
      .rst           (reset),
      .ch_enable     (ch_enable[i]),
      .force_retrain (force_retrain[i]),
      .clr_counters  (clr_counters),
      .channel_up    (channel_up[i]),
      .hard_err      (hard_err[i]),
      .core_reset    (core_reset[i]),
      .core_gt_reset (core_gt_reset[i]),
      .link_ok       (link_ok[i]),
      .ch_state      (ch_state[i*STATE_W +: STATE_W]),
      .down_count    (down_count[i*CNT_W +: CNT_W]),
      .retry_count   (retry_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Self-checking bench for aurora_link_supervisor: directed scenarios plus randomized
// traffic checked against a countdown-based behavioural model.
module tb_aurora_link_supervisor;

  localparam int NCH = 2, GT = 8, CORE = 4, UPT = 32, DBC = 4, MAXR = 2, CW = 2;
  localparam int S_DIS = 0, S_GT = 1, S_CORE = 2, S_WAIT = 3, S_UP = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] ch_enable, force_retrain, channel_up, hard_err;
  logic clr_counters;
  logic [NCH-1:0] core_reset, core_gt_reset, link_ok;
  logic [3*NCH-1:0] ch_state;
  logic [CW*NCH-1:0] down_count, retry_count;

  int checks = 0;
  int errors = 0;

  // Model state: phase, remaining cycles in the timed phase, low-run length, retries.
  int m_st[NCH], m_left[NCH], m_low[NCH], m_tries[NCH], m_dn[NCH], m_rt[NCH];
  bit m_up1[NCH], m_up2[NCH], m_err1[NCH], m_err2[NCH];

  always #5 clk = ~clk;

  aurora_link_supervisor #(
    .NUM_CH(NCH), .GT_RST_CYC(GT), .CORE_RST_CYC(CORE), .UP_TIMEOUT(UPT),
    .DOWN_DEBOUNCE(DBC), .MAX_RETRY(MAXR), .CNT_W(CW)
  ) dut (
    .init_clk_in(clk), .reset(rst), .ch_enable(ch_enable), .force_retrain(force_retrain),
    .clr_counters(clr_counters), .channel_up(channel_up), .hard_err(hard_err),
    .core_reset(core_reset), .core_gt_reset(core_gt_reset), .link_ok(link_ok),
    .ch_state(ch_state), .down_count(down_count), .retry_count(retry_count)
  );

  function automatic int phase_len(input int st);
    case (st)
      S_GT:    return GT;
      S_CORE:  return CORE;
      S_WAIT:  return UPT;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = S_DIS; m_left[c] = 0; m_low[c] = 0; m_tries[c] = 0;
      m_dn[c] = 0; m_rt[c] = 0;
      m_up1[c] = 0; m_up2[c] = 0; m_err1[c] = 0; m_err2[c] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int ns;
      bit dn, rt, forced;
      ns = m_st[c]; dn = 0; rt = 0; forced = 0;
      case (m_st[c])
        S_DIS: if (ch_enable[c]) ns = S_GT;
        S_GT: begin
          m_tries[c] = 0;
          if (m_left[c] == 1) ns = S_CORE; else m_left[c]--;
        end
        S_CORE: if (m_left[c] == 1) ns = S_WAIT; else m_left[c]--;
        S_WAIT: begin
          if (m_up2[c]) ns = S_UP;
          else if (m_left[c] == 1) begin
            rt = 1; m_tries[c]++;
            ns = (m_tries[c] >= MAXR) ? S_GT : S_CORE;
          end else m_left[c]--;
        end
        default: begin
          if (m_err2[c]) begin dn = 1; ns = S_CORE; end
          else if (!m_up2[c]) begin
            m_low[c]++;
            if (m_low[c] >= DBC) begin dn = 1; ns = S_CORE; end
          end else m_low[c] = 0;
        end
      endcase
      if (force_retrain[c] && m_st[c] != S_DIS) begin ns = S_GT; dn = 0; rt = 0; forced = 1; end
      if (!ch_enable[c]) begin ns = S_DIS; dn = 0; rt = 0; end
      if (ns != m_st[c] || forced) begin m_low[c] = 0; m_left[c] = phase_len(ns); end
      if (clr_counters) begin m_dn[c] = 0; m_rt[c] = 0; end
      else begin
        if (dn && m_dn[c] < CMAX) m_dn[c]++;
        if (rt && m_rt[c] < CMAX) m_rt[c]++;
      end
      m_st[c] = ns;
      m_up2[c] = m_up1[c]; m_up1[c] = channel_up[c];
      m_err2[c] = m_err1[c]; m_err1[c] = hard_err[c];
    end
  endtask

  task automatic model_out(output logic [NCH-1:0] e_rst, output logic [NCH-1:0] e_gt,
                           output logic [NCH-1:0] e_ok, output logic [3*NCH-1:0] e_st,
                           output logic [CW*NCH-1:0] e_dn, output logic [CW*NCH-1:0] e_rt);
    for (int c = 0; c < NCH; c++) begin
      e_rst[c] = (m_st[c] <= S_CORE);
      e_gt[c]  = (m_st[c] <= S_GT);
      e_ok[c]  = (m_st[c] == S_UP);
      e_st[c*3 +: 3]   = 3'(m_st[c]);
      e_dn[c*CW +: CW] = CW'(m_dn[c]);
      e_rt[c*CW +: CW] = CW'(m_rt[c]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int c, input int st, input int budget, input string nm);
    int n = 0;
    while (int'(ch_state[c*3 +: 3]) != st && n < budget) begin tick(); n++; end
    checks++;
    if (int'(ch_state[c*3 +: 3]) != st) begin
      errors++;
      $display("FAIL %s wait ch%0d state got %0d want %0d", nm, c, ch_state[c*3 +: 3], st);
    end
  endtask

  task automatic test_reset();
    rst = 1; ch_enable = '0; force_retrain = '0; channel_up = '0; hard_err = '0;
    clr_counters = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (core_reset !== 2'b11) begin errors++; $display("FAIL reset core_reset got %b want 11", core_reset); end
    checks++; if (core_gt_reset !== 2'b11) begin errors++; $display("FAIL reset gt_reset got %b want 11", core_gt_reset); end
    checks++; if (link_ok !== 2'b00) begin errors++; $display("FAIL reset link_ok got %b want 00", link_ok); end
    checks++; if (ch_state !== 6'd0) begin errors++; $display("FAIL reset ch_state got %h want 0", ch_state); end
    checks++; if (down_count !== 4'd0 || retry_count !== 4'd0) begin
      errors++; $display("FAIL reset counters got %h/%h want 0/0", down_count, retry_count);
    end
    rst = 0;
    model_reset();
    tick();
    checks++; if (ch_state !== 6'd0) begin errors++; $display("FAIL reset_hold ch_state got %h want 0", ch_state); end
  endtask

  task automatic test_power_up();
    ch_enable = 2'b01;
    for (int i = 1; i <= 14; i++) begin
      int es;
      tick();
      es = (i <= GT) ? S_GT : (i <= GT + CORE) ? S_CORE : S_WAIT;
      checks++; if (int'(ch_state[2:0]) != es) begin errors++; $display("FAIL pwrup ch0 state cyc %0d got %0d want %0d", i, ch_state[2:0], es); end
      checks++; if (core_gt_reset[0] !== (i <= GT)) begin errors++; $display("FAIL pwrup ch0 gt_reset cyc %0d got %b", i, core_gt_reset[0]); end
      checks++; if (core_reset[0] !== (i <= GT + CORE)) begin errors++; $display("FAIL pwrup ch0 reset cyc %0d got %b", i, core_reset[0]); end
      checks++; if (ch_state[5:3] !== 3'd0 || core_reset[1] !== 1'b1 || core_gt_reset[1] !== 1'b1) begin
        errors++; $display("FAIL pwrup ch1 idle cyc %0d state %0d rst %b gt %b", i, ch_state[5:3], core_reset[1], core_gt_reset[1]);
      end
    end
  endtask

  task automatic test_bringup();
    channel_up[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (link_ok[0] !== (i == 3)) begin errors++; $display("FAIL bringup link_ok cyc %0d got %b want %b", i, link_ok[0], i == 3); end
    end
    checks++; if (ch_state[2:0] !== 3'd4) begin errors++; $display("FAIL bringup state got %0d want 4", ch_state[2:0]); end
    checks++; if (down_count !== 4'd0 || retry_count !== 4'd0) begin
      errors++; $display("FAIL bringup counters got %h/%h want 0/0", down_count, retry_count);
    end
  endtask

  task automatic test_timeout();
    ch_enable = 2'b11;
    for (int i = 1; i <= 81; i++) begin
      tick();
      if (i == 44) begin
        checks++; if (ch_state[5:3] !== 3'd3 || retry_count[3:2] !== 2'd0) begin
          errors++; $display("FAIL timeout1_pre state %0d retry %0d want 3/0", ch_state[5:3], retry_count[3:2]);
        end
      end
      if (i == 45) begin
        checks++; if (ch_state[5:3] !== 3'd2 || retry_count[3:2] !== 2'd1 || core_gt_reset[1] !== 1'b0) begin
          errors++; $display("FAIL timeout1 state %0d retry %0d gt %b want 2/1/0", ch_state[5:3], retry_count[3:2], core_gt_reset[1]);
        end
      end
      if (i == 81) begin
        checks++; if (ch_state[5:3] !== 3'd1 || retry_count[3:2] !== 2'd2 || core_gt_reset[1] !== 1'b1 || core_reset[1] !== 1'b1) begin
          errors++; $display("FAIL timeout2 state %0d retry %0d gt %b rst %b want 1/2/1/1", ch_state[5:3], retry_count[3:2], core_gt_reset[1], core_reset[1]);
        end
      end
    end
  endtask

  task automatic test_debounce();
    channel_up[0] = 1'b0;
    repeat (3) tick();
    channel_up[0] = 1'b1;
    repeat (6) tick();
    checks++; if (ch_state[2:0] !== 3'd4 || down_count[1:0] !== 2'd0) begin
      errors++; $display("FAIL glitch state %0d down %0d want 4/0", ch_state[2:0], down_count[1:0]);
    end
    channel_up[0] = 1'b0;
    repeat (5) tick();
    checks++; if (ch_state[2:0] !== 3'd4) begin errors++; $display("FAIL debounce_early state got %0d want 4", ch_state[2:0]); end
    tick();
    checks++; if (ch_state[2:0] !== 3'd2 || down_count[1:0] !== 2'd1) begin
      errors++; $display("FAIL debounce state %0d down %0d want 2/1", ch_state[2:0], down_count[1:0]);
    end
    channel_up[0] = 1'b1;
    wait_state(0, S_UP, 60, "debounce_recover");
  endtask

  task automatic test_priority();
    hard_err[0] = 1'b1;
    tick(); tick();
    force_retrain[0] = 1'b1;
    tick();
    force_retrain[0] = 1'b0; hard_err[0] = 1'b0;
    checks++; if (ch_state[2:0] !== 3'd1 || core_gt_reset[0] !== 1'b1 || down_count[1:0] !== 2'd1) begin
      errors++; $display("FAIL prio_force state %0d gt %b down %0d want 1/1/1", ch_state[2:0], core_gt_reset[0], down_count[1:0]);
    end
    wait_state(0, S_UP, 60, "prio_recover");
    ch_enable[0] = 1'b0; force_retrain[0] = 1'b1;
    tick();
    force_retrain[0] = 1'b0;
    checks++; if (ch_state[2:0] !== 3'd0 || link_ok[0] !== 1'b0 || core_reset[0] !== 1'b1 || core_gt_reset[0] !== 1'b1) begin
      errors++; $display("FAIL prio_disable state %0d ok %b rst %b gt %b want 0/0/1/1", ch_state[2:0], link_ok[0], core_reset[0], core_gt_reset[0]);
    end
    ch_enable[0] = 1'b1;
    wait_state(0, S_UP, 60, "prio_reenable");
  endtask

  task automatic test_saturation();
    clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
    checks++; if (down_count !== 4'd0 || retry_count !== 4'd0) begin
      errors++; $display("FAIL clr counters got %h/%h want 0/0", down_count, retry_count);
    end
    for (int k = 0; k < 5; k++) begin
      hard_err[0] = 1'b1;
      tick(); tick();
      hard_err[0] = 1'b0;
      tick();
      wait_state(0, S_UP, 40, "sat_loss");
    end
    checks++; if (down_count[1:0] !== 2'd3) begin errors++; $display("FAIL saturate down got %0d want 3", down_count[1:0]); end
    hard_err[0] = 1'b1;
    tick(); tick();
    hard_err[0] = 1'b0; clr_counters = 1'b1;
    tick();
    clr_counters = 1'b0;
    checks++; if (down_count[1:0] !== 2'd0 || ch_state[2:0] !== 3'd2) begin
      errors++; $display("FAIL clr_with_loss down %0d state %0d want 0/2", down_count[1:0], ch_state[2:0]);
    end
  endtask

  task automatic test_reset_mid();
    force_retrain[0] = 1'b1;
    tick();
    force_retrain[0] = 1'b0;
    repeat (2) tick();
    #3 rst = 1'b1;
    #1;
    checks++; if (core_reset !== 2'b11 || core_gt_reset !== 2'b11 || link_ok !== 2'b00) begin
      errors++; $display("FAIL midreset outputs rst %b gt %b ok %b want 11/11/00", core_reset, core_gt_reset, link_ok);
    end
    checks++; if (ch_state !== 6'd0 || down_count !== 4'd0 || retry_count !== 4'd0) begin
      errors++; $display("FAIL midreset state %h counters %h/%h want 0", ch_state, down_count, retry_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int up_run[NCH], err_run[NCH];
    logic [NCH-1:0] e_rst, e_gt, e_ok;
    logic [3*NCH-1:0] e_st;
    logic [CW*NCH-1:0] e_dn, e_rt;
    for (int c = 0; c < NCH; c++) begin up_run[c] = 0; err_run[c] = 0; end
    ch_enable = 2'b11;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (up_run[c] == 0) begin
          channel_up[c] = ~channel_up[c];
          up_run[c] = channel_up[c] ? int'($urandom_range(5, 80)) : int'($urandom_range(1, 45));
        end
        up_run[c]--;
        if (err_run[c] > 0) err_run[c]--;
        else if ($urandom_range(0, 149) == 0) err_run[c] = int'($urandom_range(2, 3));
        hard_err[c]      = (err_run[c] > 0);
        force_retrain[c] = ($urandom_range(0, 299) == 0);
        ch_enable[c]     = ($urandom_range(0, 399) != 0);
      end
      clr_counters = ($urandom_range(0, 249) == 0);
      tick();
      model_out(e_rst, e_gt, e_ok, e_st, e_dn, e_rt);
      checks++; if (core_reset !== e_rst) begin errors++; $display("FAIL rand core_reset cyc %0d got %b want %b", cyc, core_reset, e_rst); end
      checks++; if (core_gt_reset !== e_gt) begin errors++; $display("FAIL rand gt_reset cyc %0d got %b want %b", cyc, core_gt_reset, e_gt); end
      checks++; if (link_ok !== e_ok) begin errors++; $display("FAIL rand link_ok cyc %0d got %b want %b", cyc, link_ok, e_ok); end
      checks++; if (ch_state !== e_st) begin errors++; $display("FAIL rand ch_state cyc %0d got %h want %h", cyc, ch_state, e_st); end
      checks++; if (down_count !== e_dn) begin errors++; $display("FAIL rand down_count cyc %0d got %h want %h", cyc, down_count, e_dn); end
      checks++; if (retry_count !== e_rt) begin errors++; $display("FAIL rand retry_count cyc %0d got %h want %h", cyc, retry_count, e_rt); end
    end
    force_retrain = '0; hard_err = '0; clr_counters = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_bringup();
    test_timeout();
    test_debounce();
    test_priority();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_link_supervisor.md
Name: aurora_link_supervisor

Overview:
Parametrised reset sequencer and link watchdog for NUM_CH Aurora 8b10b channel cores, all running from the shared init clock.
- Drives each core's reset and gt_reset in the required order.
- Waits for channel_up, with retries on timeout.
- Detects link loss and hard errors, and re-trains automatically.
- Exposes per-channel state and saturating event counters to the control register block.

Parameters:
NUM_CH, 4, number of Aurora channels supervised (1..16)
GT_RST_CYC, 128, init_clk cycles gt_reset (and reset) held asserted
CORE_RST_CYC, 64, init_clk cycles reset held after gt_reset deasserts
UP_TIMEOUT, 2**20, init_clk cycles to wait for channel_up before retry
DOWN_DEBOUNCE, 16, consecutive cycles channel_up must be low to count as link loss
MAX_RETRY, 4, core-only retries before escalating to a full GT reset
CNT_W, 16, width of event counters

Ports:
init_clk_in  in  1  supervisor clock (free-running init clock)
reset  in  1  asynchronous, active-high reset
ch_enable  in  NUM_CH  per-channel enable; low forces and holds channel in reset
force_retrain  in  NUM_CH  single-cycle pulse per channel: restart from full GT reset
clr_counters  in  1  single-cycle pulse: zero all counters
channel_up  in  NUM_CH  from cores (user_clk domain, async here)
hard_err  in  NUM_CH  from cores (async; held >=2 init_clk cycles by the core)
core_reset  out  NUM_CH  to core reset input
core_gt_reset  out  NUM_CH  to core gt_reset input
link_ok  out  NUM_CH  registered: channel in UP state
ch_state  out  3*NUM_CH  encoded FSM state per channel
down_count  out  CNT_W*NUM_CH  saturating count of UP->link-loss/hard_err events
retry_count  out  CNT_W*NUM_CH  saturating count of WAIT_UP timeouts

Behaviour:
- Reset (async assert, sync release):
  - all channels in DISABLED; core_reset=1, core_gt_reset=1, link_ok=0
  - counters=0; ch_state=0
- channel_up and hard_err pass through 2-flop synchronizers. All decisions use the synchronized values; this adds 2 cycles of latency.
- Per-channel FSM; encodings: DISABLED=0, RST_GT=1, RST_CORE=2, WAIT_UP=3, UP=4.
- DISABLED:
  - Outputs: reset=1, gt_reset=1.
  - Exit: ch_enable=1 -> RST_GT on the next cycle.
- RST_GT:
  - Outputs: reset=1, gt_reset=1.
  - Duration: exactly GT_RST_CYC cycles, then -> RST_CORE. The local retry counter clears here.
- RST_CORE:
  - Outputs: reset=1, gt_reset=0.
  - Duration: exactly CORE_RST_CYC cycles, then -> WAIT_UP.
- WAIT_UP:
  - Outputs: reset=0, gt_reset=0.
  - Sync channel_up=1 -> UP.
  - UP_TIMEOUT cycles elapse -> retry_count+1 (saturating) and local retry counter+1.
  - After a timeout: if the local retry counter reaches MAX_RETRY, go to RST_GT; otherwise go to RST_CORE.
- UP:
  - Outputs: reset=0, gt_reset=0, link_ok=1.
  - sync hard_err=1 -> RST_CORE immediately.
  - sync channel_up low for DOWN_DEBOUNCE consecutive cycles -> RST_CORE. A shorter glitch restarts the debounce counter and the channel stays in UP.
  - Either exit increments down_count (saturating).
- Ordering invariant: gt_reset is never 1 while reset is 0. Every transition into RST_GT asserts both outputs in the same cycle.
- Event priority within a cycle: ch_enable=0 > force_retrain > hard_err > timeout/debounce.
  - ch_enable=0 from any state -> DISABLED next cycle.
  - force_retrain from any non-DISABLED state -> RST_GT. It does not count as a down or retry event.
- Counters:
  - Saturate at 2**CNT_W-1.
  - clr_counters zeroes them next cycle. If an increment coincides with clr_counters, the result is 0.
- link_ok and ch_state are registered and change in the same cycle as the state register.
- Reset asserted mid-sequence: all channels return to DISABLED asynchronously and outputs take their reset values.

Decomposition:
- Shared package aurora_link_pkg:
  - state enum (3-bit encodings above)
  - CNT_W default
  - state-to-output decode function
- One sub-module, aurora_link_supervisor_ch: single-channel FSM, timers, synchronizers and counters, instantiated NUM_CH times in a generate loop.
- Timer width is $clog2 of the largest of GT_RST_CYC, CORE_RST_CYC and UP_TIMEOUT.

Test Plan:
Bench parameters: NUM_CH=2, GT_RST_CYC=8, CORE_RST_CYC=4, UP_TIMEOUT=32, DOWN_DEBOUNCE=4, MAX_RETRY=2.
- Power-up: release reset, ch_enable=2'b01 -> ch0 has gt_reset=1 for 8 cycles, then reset=1 for 4 more; ch1 stays DISABLED with both resets=1.
- Link bring-up: raise channel_up[0] in WAIT_UP -> link_ok[0]=1 exactly 3 cycles later (2 sync + 1 register); counters remain 0.
- Timeout escalation: channel_up held 0 -> retry_count=1 after the first 32-cycle wait, with re-entry to RST_CORE; the second timeout gives retry_count=2 and re-entry to RST_GT (gt_reset reasserted).
- Debounce: in UP, a 3-cycle channel_up low glitch -> remains UP, down_count=0; a 4-cycle low -> RST_CORE, down_count=1.
- Priority: hard_err and force_retrain in the same cycle in UP -> RST_GT, down_count unchanged; ch_enable=0 in the same cycle -> DISABLED.
- Saturation/clear: with CNT_W=2, 5 link losses -> down_count=3; clr_counters coinciding with a 6th loss -> down_count=0.
